// File: rtl/spi_arbiter_if.sv
// Command-port bundle between the requesters, the arbiter and the spi_interface engine.
// The arbiter takes the slave view; requesters and engine together drive the master view.
interface spi_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int LEN_W = 16
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic [N_REQ-1:0]       req_op;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [N_REQ-1:0]       err;
    logic [LEN_W-1:0]       len;
    logic                   op;
    logic                   work;
    logic                   busy;

    modport slave (
        input  req, req_len, req_op, busy,
        output gnt, done, err, len, op, work
    );

    modport master (
        output req, req_len, req_op, busy,
        input  gnt, done, err, len, op, work
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_interface command port between N_REQ requesters.
// The winner's command is latched onto the engine and a watchdog guards each transaction.
module spi_arbiter #(
    parameter int N_REQ   = 2,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input logic          clk,
    input logic          rst,
    spi_arbiter_if.slave bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX   = '1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        RUN,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             op_q, op_d;
    logic             work_q, work_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic             found;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] cand;
    logic [LEN_W-1:0] pick_len;
    logic [WD_W-1:0]  wd_inc;
    logic             timeout_hit;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return PTR_W'(sum);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] sel);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // First requesting index at or above ptr, wrapping back to zero.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = wrap_inc(ptr_q, i);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign pick_len    = bus.req_len[int'(pick)*LEN_W +: LEN_W];
    assign wd_inc      = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (wd_q >= WD_LIMIT);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        len_d   = len_q;
        op_d    = op_q;
        work_d  = 1'b0;
        wd_d    = wd_q;

        case (state_q)
            IDLE: begin
                if (!bus.busy && found) begin
                    win_d = pick;
                    if (pick_len == '0) begin
                        err_d = onehot(pick);
                        ptr_d = wrap_inc(pick, 1);
                    end else begin
                        state_d = START;
                        gnt_d   = onehot(pick);
                        work_d  = 1'b1;
                        len_d   = pick_len;
                        op_d    = bus.req_op[pick];
                        wd_d    = '0;
                    end
                end
            end

            START: begin
                state_d = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                wd_d = wd_inc;
                if (bus.busy) begin
                    state_d = RUN;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = onehot(win_q);
                    gnt_d   = '0;
                    ptr_d   = wrap_inc(win_q, 1);
                end
            end

            // A completing engine wins over a watchdog expiring in the same cycle.
            RUN: begin
                wd_d = wd_inc;
                if (!bus.busy) begin
                    state_d = FINISH;
                    done_d  = onehot(win_q);
                    gnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = onehot(win_q);
                    gnt_d   = '0;
                    ptr_d   = wrap_inc(win_q, 1);
                end
            end

            FINISH: begin
                state_d = IDLE;
                ptr_d   = wrap_inc(win_q, 1);
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            len_q   <= '0;
            op_q    <= 1'b0;
            work_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            len_q   <= len_d;
            op_q    <= op_d;
            work_q  <= work_d;
            wd_q    <= wd_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.len  = len_q;
    assign bus.op   = op_q;
    assign bus.work = work_q;

    // Grant and status pulses never name more than one requester; the command is frozen while granted.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(done_q));
    a_err_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(err_q));
    a_cmd_stable: assert property (@(posedge clk) disable iff (!rst)
        (gnt_q != '0 && $past(gnt_q) != '0) |-> ($stable(len_q) && $stable(op_q)));

endmodule
